matmul_dot_engine: RTL and testbench
====================================

# matmul_dot_engine

Parametrised, runtime-configurable dot-product engine for the matmul path. It reads rows of A and of B (B stored transposed) from external row memories, `LANES` elements per beat, and accumulates signed fixed-point dot products. It writes one requantised `DATA_WIDTH` result per (i, j) into the output memory. Compared with the fixed 64x128 generation, it adds runtime M/N/K, selectable output modes (wrap, saturate, ReLU) and configuration error reporting.

## Interface
- `DATA_WIDTH`, 16, element width, signed two's complement
- `LANES`, 8, elements per memory beat (multipliers)
- `K_MAX`, 128, max elements per row; `BEATS_MAX = K_MAX/LANES`
- `ROWS_MAX`, 64, max rows of A (M) and of B (N)
- `ACC_WIDTH`, 40, accumulator width
- `FRAC_BITS`, 8, arithmetic right shift applied before requantisation
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; sampled only in IDLE
- `cfg_m`, `cfg_n`  in  clog2(ROWS_MAX)+1  row counts; latched on an accepted start
- `cfg_k_beats`  in  clog2(BEATS_MAX)+1  beats per row; latched on start
- `cfg_mode`  in  2  0 wrap, 1 saturate, 2 ReLU+saturate, 3 is treated as 1
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  bad config; sticky until the next accepted start
- `a_rd_en`, `b_rd_en`  out  1  read strobes
- `a_rd_addr`, `b_rd_addr`  out  clog2(ROWS_MAX*BEATS_MAX)  = row*BEATS_MAX + beat
- `a_rd_data`, `b_rd_data`  in  LANES*DATA_WIDTH  valid the cycle after the strobe; lane 0 is LSBs
- `out_we`  out  1  output write strobe
- `out_addr`  out  clog2(ROWS_MAX*ROWS_MAX)  = i*ROWS_MAX + j (fixed stride)
- `out_data`  out  DATA_WIDTH  requantised result

## Operation
- States: IDLE, CHECK, RUN (READ, DRAIN, WRITE sub-phases), DONE.
- Element order is i outer (A row), j inner (B row).
- IDLE to CHECK on `start`.
- CHECK to DONE with `err`=1 if any of these holds: m=0, n=0, kb=0, m>ROWS_MAX, n>ROWS_MAX, kb>BEATS_MAX. Otherwise CHECK goes to RUN.
- `start` is ignored in every state except IDLE.
- Per element: read beats 0..kb-1 of A row i and B row j, asserting `a_rd_en` and `b_rd_en` together.
- Datapath: multiply stage registered, then lane sum plus accumulate registered.
- Products are full 2*DATA_WIDTH signed values, sign-extended to ACC_WIDTH.
- The accumulator is loaded (not added) on beat 0 of each element. Overflow of ACC_WIDTH wraps.
- Requantise: r = acc >>> FRAC_BITS.
  - Mode 0: r[DATA_WIDTH-1:0].
  - Mode 1: clamp r to [-2^(DW-1), 2^(DW-1)-1].
  - Mode 2: r<0 gives 0, else clamp as mode 1.
- After element (m-1, n-1) is written, go to DONE, then IDLE.
- `rst` in any state returns to IDLE the next cycle. All outputs are 0, counters and accumulator are cleared, and no partial write completes.
- Reset value of every output: 0.

## Timing
- Cycle 0 is the cycle `start` is sampled high in IDLE; cycle 1 is CHECK. Define P = kb+4.
- Element e (0-based, e = i*n+j) occupies cycles e*P+2 .. e*P+P+1:
  - Reads in its first kb cycles.
  - `out_we`=1 for exactly one cycle, the last one (e*P+P+1), with `out_addr`/`out_data` valid in that cycle.
  - No overlap between elements.
- `busy`=1 from cycle 1 through the last `out_we` cycle (m*n*P+1).
- `done` pulses in cycle m*n*P+2 with `busy`=0.
- Error path: `busy`=1 in cycle 1 only, `done` pulses in cycle 2 with `err`=1, and there are no read or write strobes.
- `err` is cleared in the cycle after an accepted `start` (cycle 1).
- Read addresses are stable and valid only while the strobe is high. Outside strobes, addresses and `out_data` are held; only the strobes are qualified.

## Test plan
- Reset: hold `rst` 3 cycles mid-RUN, then release -> all outputs 0, state IDLE. A new start with m=n=kb=1 gives its first `a_rd_en` at cycle 2.
- Minimal: m=n=kb=1, mode 1, all A lanes 0x0100, all B lanes 0x0200 -> single `out_we` at cycle 6, `out_addr` 0, `out_data` 0x1000, `done` at cycle 7.
- Full size: m=n=64, kb=16, A row i every lane = i, B row j every lane = 1, mode 0 -> `out_addr` follows i*64+j in order. Each `out_data` = (128*i)>>>8 = i>>1 (low 16 bits). 4096 writes; `done` at cycle 4096*20+2 = 81922.
- Requantisation, kb=1:
  - A=B=0x7FFF in all lanes -> mode 0: 0xF800, mode 1: 0x7FFF, mode 2: 0x7FFF.
  - A=0x8000, B=0x7FFF -> mode 1: 0x8000, mode 2: 0x0000.
- Bad config: kb=0; also separately m=65 -> `done` at cycle 2, `err`=1, zero strobes. A following valid start clears `err` in cycle 1.
- Start while busy: pulse `start` with a different config during RUN -> ignored. Completion timing and output values match the original config.

Source files
------------

// File: rtl/matmul_dot_engine_if.sv
// matmul_dot_engine_if: control, row-memory read and output-write signals of the dot-product engine.
interface matmul_dot_engine_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 8,
   parameter int K_MAX      = 128,
   parameter int ROWS_MAX   = 64
);
   localparam int BEATS_MAX = K_MAX / LANES;
   localparam int CW  = $clog2(ROWS_MAX) + 1;
   localparam int KW  = $clog2(BEATS_MAX) + 1;
   localparam int RAW = $clog2(ROWS_MAX * BEATS_MAX);
   localparam int OAW = $clog2(ROWS_MAX * ROWS_MAX);
   logic                        start;
   logic [CW-1:0]               cfg_m;
   logic [CW-1:0]               cfg_n;
   logic [KW-1:0]               cfg_k_beats;
   logic [1:0]                  cfg_mode;
   logic                        busy;
   logic                        done;
   logic                        err;
   logic                        a_rd_en;
   logic                        b_rd_en;
   logic [RAW-1:0]              a_rd_addr;
   logic [RAW-1:0]              b_rd_addr;
   logic [LANES*DATA_WIDTH-1:0] a_rd_data;
   logic [LANES*DATA_WIDTH-1:0] b_rd_data;
   logic                        out_we;
   logic [OAW-1:0]              out_addr;
   logic [DATA_WIDTH-1:0]       out_data;
   modport master (
      output start, cfg_m, cfg_n, cfg_k_beats, cfg_mode, a_rd_data, b_rd_data,
      input  busy, done, err, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, out_we, out_addr, out_data
   );
   modport slave (
      input  start, cfg_m, cfg_n, cfg_k_beats, cfg_mode, a_rd_data, b_rd_data,
      output busy, done, err, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, out_we, out_addr, out_data
   );
endinterface

// File: rtl/matmul_dot_engine.sv
// matmul_dot_engine: runtime-configurable M x N x K signed dot-product engine with a
// registered multiply / lane-sum-accumulate pipeline and wrap, saturate or ReLU requantisation.
module matmul_dot_engine #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 8,
   parameter int K_MAX      = 128,
   parameter int ROWS_MAX   = 64,
   parameter int ACC_WIDTH  = 40,
   parameter int FRAC_BITS  = 8
) (
   input logic clk,
   input logic rst,
   matmul_dot_engine_if.slave bus
);
   localparam int BEATS_MAX = K_MAX / LANES;
   localparam int CW  = $clog2(ROWS_MAX) + 1;
   localparam int KW  = $clog2(BEATS_MAX) + 1;
   localparam int RW  = $clog2(ROWS_MAX);
   localparam int BW  = $clog2(BEATS_MAX);
   localparam int RAW = $clog2(ROWS_MAX * BEATS_MAX);
   localparam int OAW = $clog2(ROWS_MAX * ROWS_MAX);
   localparam int PW  = 2 * DATA_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] QMAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH-1:0] QMIN = ~QMAX;

   typedef enum logic [2:0] {IDLE, CHECK, READ, DRAIN, WRITE, DONE} state_t;
   state_t state;
   logic [CW-1:0] m, n;
   logic [KW-1:0] kb;
   logic [1:0] mode;
   logic [RW-1:0] i, j, ni, nj;
   logic [BW-1:0] beat;
   logic [1:0] dcnt;
   logic row_end, last_el, last_beat, bad;
   logic v1, f1, v2, f2;
   logic signed [PW-1:0] prod [LANES];
   logic signed [ACC_WIDTH-1:0] acc, sum, r;
   logic [DATA_WIDTH-1:0] sat, q;

   always_comb begin
      bad = m == '0 || n == '0 || kb == '0 || m > CW'(ROWS_MAX) || n > CW'(ROWS_MAX) || kb > KW'(BEATS_MAX);
      row_end = {1'b0, j} == n - CW'(1);
      last_el = row_end && {1'b0, i} == m - CW'(1);
      last_beat = {1'b0, beat} == kb - KW'(1);
      ni = row_end ? i + RW'(1) : i;
      nj = row_end ? '0 : j + RW'(1);
   end

   always_comb begin
      sum = '0;
      for (int l = 0; l < LANES; l++)
         sum = sum + {{(ACC_WIDTH-PW){prod[l][PW-1]}}, prod[l]};
   end

   always_comb begin
      r = acc >>> FRAC_BITS;
      sat = r > QMAX ? QMAX[DATA_WIDTH-1:0] : r < QMIN ? QMIN[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
      q = mode == 2'd0 ? r[DATA_WIDTH-1:0] : (mode == 2'd2 && r[ACC_WIDTH-1]) ? '0 : sat;
   end

   // Stage tags follow the read strobe: v1 = data on the bus, v2 = products registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         f1 <= 1'b0;
         v2 <= 1'b0;
         f2 <= 1'b0;
         acc <= '0;
         for (int l = 0; l < LANES; l++) prod[l] <= '0;
      end else begin
         v1 <= bus.a_rd_en;
         f1 <= bus.a_rd_en && beat == '0;
         v2 <= v1;
         f2 <= f1;
         if (v1)
            for (int l = 0; l < LANES; l++)
               prod[l] <= $signed(bus.a_rd_data[l*DATA_WIDTH +: DATA_WIDTH]) * $signed(bus.b_rd_data[l*DATA_WIDTH +: DATA_WIDTH]);
         if (v2) acc <= f2 ? sum : acc + sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         m <= '0;
         n <= '0;
         kb <= '0;
         mode <= '0;
         i <= '0;
         j <= '0;
         beat <= '0;
         dcnt <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.err <= 1'b0;
         bus.a_rd_en <= 1'b0;
         bus.b_rd_en <= 1'b0;
         bus.a_rd_addr <= '0;
         bus.b_rd_addr <= '0;
         bus.out_we <= 1'b0;
         bus.out_addr <= '0;
         bus.out_data <= '0;
      end else begin
         bus.done <= 1'b0;
         bus.out_we <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               m <= bus.cfg_m;
               n <= bus.cfg_n;
               kb <= bus.cfg_k_beats;
               mode <= bus.cfg_mode == 2'd3 ? 2'd1 : bus.cfg_mode;
               bus.err <= 1'b0;
               bus.busy <= 1'b1;
               state <= CHECK;
            end
            CHECK: if (bad) begin
               bus.err <= 1'b1;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               state <= DONE;
            end else begin
               i <= '0;
               j <= '0;
               beat <= '0;
               bus.a_rd_en <= 1'b1;
               bus.b_rd_en <= 1'b1;
               bus.a_rd_addr <= '0;
               bus.b_rd_addr <= '0;
               state <= READ;
            end
            READ: if (last_beat) begin
               bus.a_rd_en <= 1'b0;
               bus.b_rd_en <= 1'b0;
               dcnt <= '0;
               state <= DRAIN;
            end else begin
               beat <= beat + BW'(1);
               bus.a_rd_addr <= bus.a_rd_addr + RAW'(1);
               bus.b_rd_addr <= bus.b_rd_addr + RAW'(1);
            end
            // Three drain cycles: data return, product register, accumulate register.
            DRAIN: if (dcnt == 2'd2) begin
               bus.out_we <= 1'b1;
               bus.out_addr <= OAW'(i) * OAW'(ROWS_MAX) + OAW'(j);
               bus.out_data <= q;
               state <= WRITE;
            end else dcnt <= dcnt + 2'd1;
            WRITE: if (last_el) begin
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               state <= DONE;
            end else begin
               i <= ni;
               j <= nj;
               beat <= '0;
               bus.a_rd_en <= 1'b1;
               bus.b_rd_en <= 1'b1;
               bus.a_rd_addr <= RAW'(ni) * RAW'(BEATS_MAX);
               bus.b_rd_addr <= RAW'(nj) * RAW'(BEATS_MAX);
               state <= READ;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_dot_engine.sv
// tb_matmul_dot_engine: directed vectors with hand-computed results; a scoreboard queue
// holds expected writes and done pulses, and a negedge monitor pops and compares them.
module tb_matmul_dot_engine;
   localparam int DW = 16, LN = 8, BM = 16, RM = 64;
   typedef struct { int addr; int data; int cyc; } wr_t;
   typedef struct { int cyc; bit err; } dn_t;

   logic clk = 1'b0, rst = 1'b1;
   matmul_dot_engine_if bus ();
   matmul_dot_engine dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   logic [LN*DW-1:0] a_mem [RM*BM];
   logic [LN*DW-1:0] b_mem [RM*BM];
   wr_t wq [$];
   dn_t dq [$];
   wr_t w;
   dn_t d;
   int cyc = 0, t0 = 0, total = 0, bad = 0, done_cnt = 0, rd_cnt = 0, rise_cyc = -1, r0 = 0;
   logic prev_rd = 1'b0;
   logic [15:0] qa [6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
   logic [15:0] qb [6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
   int          qm [6] = '{0, 1, 2, 1, 2, 3};
   logic [15:0] qe [6] = '{16'hF800, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.a_rd_en) bus.a_rd_data <= a_mem[bus.a_rd_addr];
      if (bus.b_rd_en) bus.b_rd_data <= b_mem[bus.b_rd_addr];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc - t0);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.busy, bus.done, bus.err, bus.a_rd_en, bus.b_rd_en, bus.out_we,
                  bus.a_rd_addr, bus.b_rd_addr, bus.out_addr, bus.out_data});
   endfunction

   always @(negedge clk) begin
      if (bus.a_rd_en || bus.b_rd_en) begin
         rd_cnt++;
         chk("rd_pair", bus.a_rd_en, bus.b_rd_en);
      end
      if (bus.a_rd_en && !prev_rd) rise_cyc = cyc;
      prev_rd = bus.a_rd_en;
      if (bus.out_we) begin
         if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_write: addr %0h data %0h", bus.out_addr, bus.out_data);
         end else begin
            w = wq.pop_front();
            chk("out_addr", bus.out_addr, w.addr);
            chk("out_data", bus.out_data, w.data);
            chk("out_cycle", cyc, w.cyc);
         end
      end
      if (bus.done) begin
         done_cnt++;
         if (dq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: at cycle %0d", cyc - t0);
         end else begin
            d = dq.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("done_err", bus.err, d.err);
            chk("done_busy", bus.busy, 0);
         end
      end
   end

   task automatic fill(input int row, input int beat, input logic [15:0] av, input logic [15:0] bv);
      a_mem[row*BM+beat] = {LN{av}};
      b_mem[row*BM+beat] = {LN{bv}};
   endtask

   task automatic launch(input int m, input int n, input int kb, input int mode);
      @(negedge clk);
      bus.cfg_m = 7'(m);
      bus.cfg_n = 7'(n);
      bus.cfg_k_beats = 5'(kb);
      bus.cfg_mode = 2'(mode);
      bus.start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      chk("cycle1_busy", bus.busy, 1);
      chk("cycle1_err", bus.err, 0);
   endtask

   task automatic exp_w(input int addr, input int data, input int c);
      wq.push_back('{addr, data, t0 + c});
   endtask

   task automatic exp_d(input int c, input bit e);
      dq.push_back('{t0 + c, e});
   endtask

   task automatic wait_done(input int budget);
      int c0 = done_cnt;
      for (int k = 0; k < budget && done_cnt == c0; k++) @(negedge clk);
      if (done_cnt == c0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
      @(negedge clk);
      chk("queues_empty", wq.size() + dq.size(), 0);
      wq.delete();
      dq.delete();
   endtask

   initial begin
      bus.start = 1'b0;
      bus.cfg_m = '0;
      bus.cfg_n = '0;
      bus.cfg_k_beats = '0;
      bus.cfg_mode = '0;
      for (int a = 0; a < RM*BM; a++) begin
         a_mem[a] = '0;
         b_mem[a] = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 0);
      rst = 1'b0;
      fill(0, 0, 16'h0100, 16'h0200);
      r0 = rd_cnt;
      launch(1, 1, 1, 1);
      exp_w(0, 'h1000, 6);
      exp_d(7, 0);
      wait_done(50);
      chk("min_first_rd", rise_cyc - t0, 2);
      chk("min_rd_count", rd_cnt - r0, 1);
      for (int t = 0; t < 6; t++) begin
         fill(0, 0, qa[t], qb[t]);
         launch(1, 1, 1, qm[t]);
         exp_w(0, int'(qe[t]), 6);
         exp_d(7, 0);
         wait_done(50);
      end
      r0 = rd_cnt;
      launch(1, 1, 0, 1);
      exp_d(2, 1);
      wait_done(20);
      chk("kb0_strobes", rd_cnt - r0, 0);
      chk("kb0_err_sticky", bus.err, 1);
      r0 = rd_cnt;
      launch(65, 1, 1, 1);
      exp_d(2, 1);
      wait_done(20);
      chk("m65_strobes", rd_cnt - r0, 0);
      chk("m65_err_sticky", bus.err, 1);
      launch(1, 1, 1, 0);
      exp_w(0, 'h0400, 6);
      exp_d(7, 0);
      wait_done(50);
      chk("err_cleared", bus.err, 0);
      for (int b = 0; b < 2; b++) begin
         fill(0, b, 16'h0100, 16'h0100);
         fill(1, b, 16'h0200, 16'h0300);
      end
      launch(2, 2, 2, 0);
      exp_w(0, 'h1000, 7);
      exp_w(1, 'h3000, 13);
      exp_w(64, 'h2000, 19);
      exp_w(65, 'h6000, 25);
      exp_d(26, 0);
      repeat (2) @(negedge clk);
      bus.cfg_m = 7'd1;
      bus.cfg_n = 7'd1;
      bus.cfg_k_beats = 5'd1;
      bus.cfg_mode = 2'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(100);
      launch(2, 2, 4, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_mid_run", outs(), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_idle", outs(), 0);
      fill(0, 0, 16'h0100, 16'h0200);
      launch(1, 1, 1, 1);
      exp_w(0, 'h1000, 6);
      exp_d(7, 0);
      wait_done(50);
      chk("post_reset_first_rd", rise_cyc - t0, 2);
      for (int r = 0; r < RM; r++)
         for (int b = 0; b < BM; b++)
            fill(r, b, 16'(r), 16'h0001);
      launch(64, 64, 16, 0);
      for (int i = 0; i < RM; i++)
         for (int j = 0; j < RM; j++)
            exp_w(i*64 + j, i >> 1, (i*64 + j)*20 + 21);
      exp_d(4096*20 + 2, 0);
      wait_done(90000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
